seq_stage_controller: RTL and testbench
=======================================

// Module: seq_stage_controller
// PURPOSE
//  Multi-cycle sequencer for the sequential RV64 core. Steps one instruction through
//  IF/ID/EX/MEM/WB, drives the stage enables, the instruction/data memory handshakes and
//  the PC/regfile write strobes from decode control flags. Halts on an illegal
//  instruction, flags ERROR on a memory timeout, and keeps cycle/retire counters.
// PARAMETERS
//  CNT_W        32  width of cycle_cnt / retired_cnt (wrap modulo 2^CNT_W)
//  MEM_TIMEOUT  15  max wait cycles for imem_ack/dmem_ack; 0 disables timeout
// PORTS
//  clk           in   1      clock, rising edge
//  rst_n         in   1      reset, asynchronous, active-low
//  start         in   1      leave IDLE (ignored in every other state)
//  stop          in   1      sampled in WRITEBACK; 1 -> return to IDLE after retire
//  imem_req      out  1      fetch request, held until imem_ack
//  imem_ack      in   1      fetch data valid this cycle
//  ir_load       out  1      load instruction register (= FETCH & imem_ack)
//  dec_memread   in   1      decode flag, sampled in DECODE
//  dec_memwrite  in   1      decode flag, sampled in DECODE
//  dec_regwrite  in   1      decode flag, sampled in DECODE
//  dec_branch    in   1      decode flag, sampled in DECODE
//  dec_illegal   in   1      undefined opcode, sampled in DECODE
//  br_taken      in   1      branch compare result, sampled in EXECUTE
//  dmem_req      out  1      data access request, held until dmem_ack
//  dmem_we       out  1      1 = store (valid while dmem_req)
//  dmem_ack      in   1      data access complete
//  rf_we         out  1      register-file write strobe (1 cycle)
//  pc_we         out  1      PC update strobe (1 cycle)
//  pc_sel        out  1      0 = PC+4, 1 = branch target (valid with pc_we)
//  busy          out  1      state not IDLE/HALT/ERROR
//  halted        out  1      in HALT
//  err           out  1      in ERROR
//  cycle_cnt     out  CNT_W  cycles spent busy
//  retired_cnt   out  CNT_W  instructions retired
// BEHAVIOUR
//  Reset: state=IDLE; every output 0; counters 0; latched flags 0; wait timer 0.
//  Reset mid-operation: requests drop immediately (async), no strobe issued.
//  States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT, ERROR.
//  Strobe outputs are decoded from state; ir_load is FETCH & imem_ack.
//   IDLE:      start -> FETCH, clear cycle_cnt and retired_cnt.
//   FETCH:     imem_req=1; imem_ack -> DECODE; timeout -> ERROR.
//   DECODE:    latch dec_* flags; dec_illegal -> HALT, else -> EXECUTE.
//   EXECUTE:   latch br_taken; (memread|memwrite) -> MEMORY, else -> WRITEBACK.
//   MEMORY:    dmem_req=1, dmem_we=memwrite; dmem_ack -> WRITEBACK; timeout -> ERROR.
//   WRITEBACK: rf_we=regwrite; pc_we=1; pc_sel=branch&taken; retired_cnt+1;
//              stop -> IDLE, else -> FETCH.
//   HALT/ERROR: terminal; only rst_n exits. No strobes; counters frozen.
//  Latency with 0-wait ack: ALU/branch = 4 cycles, load/store = 5 cycles.
//  Wait timer: cleared on entry to FETCH/MEMORY, counts each cycle without ack;
//   timer==MEM_TIMEOUT with no ack -> ERROR; an ack in that same cycle wins.
//  memread and memwrite both set: treated as a store (dmem_we=1).
//  cycle_cnt increments every cycle while busy; both counters wrap silently.
//  A branch with dec_regwrite=0 never asserts rf_we; an illegal op retires nothing.
// STRUCTURE
//  seq_ctrl_defs.vh: state encodings (3-bit localparams), pc_sel encodings.
//  Sub-module mem_wait_timer: clear/enable/ack in, expired out; reused for IF and MEM.
//  FSM, flag latches and counters live in this module.
// TESTING
//  add, ack at 0 wait -> IF,ID,EX,WB in 4 cycles; rf_we=1, pc_sel=0; retired_cnt=1.
//  ld, dmem_ack after 3 waits -> dmem_req high 4 cycles, dmem_we=0; 8 cycles total.
//  sd -> dmem_we=1 in MEMORY; rf_we=0 in WB. beq, br_taken=1 -> pc_sel=1; taken=0 -> pc_sel=0.
//  Instr 0xFFFFFFFF (dec_illegal=1) -> HALT, halted=1, no pc_we, retired_cnt unchanged.
//  imem_ack withheld, MEM_TIMEOUT=15 -> err=1 after 16 FETCH cycles; ack at wait 15 -> DECODE.
//  rst_n low during MEMORY -> dmem_req=0 at once, state=IDLE, counters=0; stop=1 in WB -> IDLE.

Source files
------------

// File: rtl/seq_stage_controller_pkg.sv
// Shared types for the multi-cycle stage sequencer: state encoding, PC-select
// encoding and the latched decode/branch flag bundle.
package seq_stage_controller_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_FETCH     = 3'd1,
      ST_DECODE    = 3'd2,
      ST_EXECUTE   = 3'd3,
      ST_MEMORY    = 3'd4,
      ST_WRITEBACK = 3'd5,
      ST_HALT      = 3'd6,
      ST_ERROR     = 3'd7
   } state_e;

   localparam logic PC_SEL_SEQ    = 1'b0;
   localparam logic PC_SEL_BRANCH = 1'b1;

   typedef struct packed {
      logic memread;
      logic memwrite;
      logic regwrite;
      logic branch;
      logic taken;
   } ctrl_flags_t;

   function automatic logic state_is_busy(input state_e st);
      logic b;
      case (st)
         ST_FETCH, ST_DECODE, ST_EXECUTE, ST_MEMORY, ST_WRITEBACK: b = 1'b1;
         default:                                                  b = 1'b0;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/seq_stage_controller_if.sv
// Instruction/data memory handshake bundle between the sequencer (master)
// and the memory side (slave).
interface seq_stage_controller_if;
   logic imem_req;
   logic imem_ack;
   logic ir_load;
   logic dmem_req;
   logic dmem_we;
   logic dmem_ack;

   modport master (
      output imem_req, ir_load, dmem_req, dmem_we,
      input  imem_ack, dmem_ack
   );

   modport slave (
      input  imem_req, ir_load, dmem_req, dmem_we,
      output imem_ack, dmem_ack
   );
endinterface

// File: rtl/seq_stage_controller_timer.sv
// Memory wait timer: counts unacknowledged wait cycles and flags expiry when
// the count reaches MEM_TIMEOUT without an ack (MEM_TIMEOUT == 0 disables it).
module seq_stage_controller_timer #(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   input  logic ack,
   output logic expired
);
   localparam int unsigned TW = (MEM_TIMEOUT > 32'd0) ? $clog2(MEM_TIMEOUT + 32'd1) : 1;
   localparam logic [TW-1:0] LIMIT = TW'(MEM_TIMEOUT);
   localparam logic TIMEOUT_ON = (MEM_TIMEOUT != 32'd0);

   logic [TW-1:0] count_r;
   logic          at_limit_s;

   assign at_limit_s = TIMEOUT_ON && (count_r == LIMIT);
   // an ack in the limit cycle still wins over expiry
   assign expired    = enable && !ack && at_limit_s;

   // wait-cycle counter, saturating at the limit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= '0;
      end else if (clear) begin
         count_r <= '0;
      end else if (TIMEOUT_ON && enable && !ack && !at_limit_s) begin
         count_r <= count_r + TW'(1);
      end else begin
         count_r <= count_r;
      end
   end
endmodule

// File: rtl/seq_stage_controller.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer for the sequential RV64 core: stage
// handshakes, PC/regfile strobes, halt/error terminals and cycle/retire counters.
module seq_stage_controller
   import seq_stage_controller_pkg::*;
#(
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   stop,
   seq_stage_controller_if.master mem,
   input  logic                   dec_memread,
   input  logic                   dec_memwrite,
   input  logic                   dec_regwrite,
   input  logic                   dec_branch,
   input  logic                   dec_illegal,
   input  logic                   br_taken,
   output logic                   rf_we,
   output logic                   pc_we,
   output logic                   pc_sel,
   output logic                   busy,
   output logic                   halted,
   output logic                   err,
   output logic [CNT_W-1:0]       cycle_cnt,
   output logic [CNT_W-1:0]       retired_cnt
);
   state_e            state_r, state_s;
   ctrl_flags_t       flags_r, flags_s;
   logic              in_fetch_s, in_memory_s;
   logic              if_expired_s, mem_expired_s;
   logic              imem_req_r, dmem_req_r, dmem_we_r;
   logic              rf_we_r, pc_we_r, pc_sel_r;
   logic              busy_r, halted_r, err_r;
   logic [CNT_W-1:0]  cycle_cnt_r, retired_cnt_r;

   assign in_fetch_s  = (state_r == ST_FETCH);
   assign in_memory_s = (state_r == ST_MEMORY);

   seq_stage_controller_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_if_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (!in_fetch_s),
      .enable  (in_fetch_s),
      .ack     (mem.imem_ack),
      .expired (if_expired_s)
   );

   seq_stage_controller_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_mem_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (!in_memory_s),
      .enable  (in_memory_s),
      .ack     (mem.dmem_ack),
      .expired (mem_expired_s)
   );

   // next-state and flag-latch decode
   always_comb begin
      state_s = state_r;
      flags_s = flags_r;
      case (state_r)
         ST_IDLE: begin
            if (start) state_s = ST_FETCH;
            else       state_s = ST_IDLE;
         end
         ST_FETCH: begin
            if (mem.imem_ack)      state_s = ST_DECODE;
            else if (if_expired_s) state_s = ST_ERROR;
            else                   state_s = ST_FETCH;
         end
         ST_DECODE: begin
            flags_s.memread  = dec_memread;
            flags_s.memwrite = dec_memwrite;
            flags_s.regwrite = dec_regwrite;
            flags_s.branch   = dec_branch;
            if (dec_illegal) state_s = ST_HALT;
            else             state_s = ST_EXECUTE;
         end
         ST_EXECUTE: begin
            flags_s.taken = br_taken;
            if (flags_r.memread || flags_r.memwrite) state_s = ST_MEMORY;
            else                                     state_s = ST_WRITEBACK;
         end
         ST_MEMORY: begin
            if (mem.dmem_ack)       state_s = ST_WRITEBACK;
            else if (mem_expired_s) state_s = ST_ERROR;
            else                    state_s = ST_MEMORY;
         end
         ST_WRITEBACK: begin
            if (stop) state_s = ST_IDLE;
            else      state_s = ST_FETCH;
         end
         ST_HALT:  state_s = ST_HALT;
         ST_ERROR: state_s = ST_ERROR;
         default:  state_s = ST_ERROR;
      endcase
   end

   // state and latched decode flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         flags_r <= '0;
      end else begin
         state_r <= state_s;
         flags_r <= flags_s;
      end
   end

   // outputs registered from the next-state decode so they align with the state they describe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         imem_req_r <= 1'b0;
         dmem_req_r <= 1'b0;
         dmem_we_r  <= 1'b0;
         rf_we_r    <= 1'b0;
         pc_we_r    <= 1'b0;
         pc_sel_r   <= PC_SEL_SEQ;
         busy_r     <= 1'b0;
         halted_r   <= 1'b0;
         err_r      <= 1'b0;
      end else begin
         imem_req_r <= (state_s == ST_FETCH);
         dmem_req_r <= (state_s == ST_MEMORY);
         dmem_we_r  <= (state_s == ST_MEMORY) && flags_s.memwrite;
         rf_we_r    <= (state_s == ST_WRITEBACK) && flags_s.regwrite;
         pc_we_r    <= (state_s == ST_WRITEBACK);
         pc_sel_r   <= ((state_s == ST_WRITEBACK) && flags_s.branch && flags_s.taken)
                       ? PC_SEL_BRANCH : PC_SEL_SEQ;
         busy_r     <= state_is_busy(state_s);
         halted_r   <= (state_s == ST_HALT);
         err_r      <= (state_s == ST_ERROR);
      end
   end

   // cycle and retire counters; cleared on start, frozen outside busy states
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_cnt_r   <= '0;
         retired_cnt_r <= '0;
      end else if ((state_r == ST_IDLE) && start) begin
         cycle_cnt_r   <= '0;
         retired_cnt_r <= '0;
      end else begin
         cycle_cnt_r   <= state_is_busy(state_r) ? cycle_cnt_r + CNT_W'(1) : cycle_cnt_r;
         retired_cnt_r <= (state_r == ST_WRITEBACK) ? retired_cnt_r + CNT_W'(1) : retired_cnt_r;
      end
   end

   assign mem.imem_req = imem_req_r;
   assign mem.ir_load  = in_fetch_s && mem.imem_ack;
   assign mem.dmem_req = dmem_req_r;
   assign mem.dmem_we  = dmem_we_r;
   assign rf_we        = rf_we_r;
   assign pc_we        = pc_we_r;
   assign pc_sel       = pc_sel_r;
   assign busy         = busy_r;
   assign halted       = halted_r;
   assign err          = err_r;
   assign cycle_cnt    = cycle_cnt_r;
   assign retired_cnt  = retired_cnt_r;
endmodule

// File: tb/tb_seq_stage_controller.sv
// Randomized bench: builds an expected per-cycle timeline from instruction-level
// phase lengths (fetch waits, memory waits) and compares the sequencer against it.
module tb_seq_stage_controller;

   localparam int TMO = 15;

   localparam logic [9:0] E_IREQ  = 10'b10_0000_0000;
   localparam logic [9:0] E_IRLD  = 10'b01_0000_0000;
   localparam logic [9:0] E_DREQ  = 10'b00_1000_0000;
   localparam logic [9:0] E_DWE   = 10'b00_0100_0000;
   localparam logic [9:0] E_RFWE  = 10'b00_0010_0000;
   localparam logic [9:0] E_PCWE  = 10'b00_0001_0000;
   localparam logic [9:0] E_PCSEL = 10'b00_0000_1000;
   localparam logic [9:0] E_BUSY  = 10'b00_0000_0100;
   localparam logic [9:0] E_HALT  = 10'b00_0000_0010;
   localparam logic [9:0] E_ERR   = 10'b00_0000_0001;

   typedef struct {
      int fw; int dw;
      bit mr; bit mw; bit rw; bit br; bit tk; bit ill; bit stop;
   } instr_t;

   typedef struct {
      logic start; logic stop; logic iack; logic dack;
      logic mr; logic mw; logic rw; logic br; logic ill; logic tk;
      logic [9:0] exp;
      bit busy; bit wb; bit clr;
   } cyc_t;

   logic        clk;
   logic        rst_n;
   logic        start, stop;
   logic        dec_memread, dec_memwrite, dec_regwrite, dec_branch, dec_illegal, br_taken;
   logic        rf_we, pc_we, pc_sel, busy, halted, err;
   logic [31:0] cycle_cnt, retired_cnt;

   seq_stage_controller_if mem_if ();

   seq_stage_controller #(.CNT_W(32), .MEM_TIMEOUT(TMO)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .stop         (stop),
      .mem          (mem_if),
      .dec_memread  (dec_memread),
      .dec_memwrite (dec_memwrite),
      .dec_regwrite (dec_regwrite),
      .dec_branch   (dec_branch),
      .dec_illegal  (dec_illegal),
      .br_taken     (br_taken),
      .rf_we        (rf_we),
      .pc_we        (pc_we),
      .pc_sel       (pc_sel),
      .busy         (busy),
      .halted       (halted),
      .err          (err),
      .cycle_cnt    (cycle_cnt),
      .retired_cnt  (retired_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_chk  = 0;
   int          n_fail = 0;
   logic [31:0] m_cyc  = 32'd0;
   logic [31:0] m_ret  = 32'd0;
   cyc_t        tl[$];
   instr_t      prog[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [9:0] outs();
      return {mem_if.imem_req, mem_if.ir_load, mem_if.dmem_req, mem_if.dmem_we,
              rf_we, pc_we, pc_sel, busy, halted, err};
   endfunction

   function automatic instr_t mk(int fw, int dw, bit mr, bit mw, bit rw, bit br, bit tk, bit ill, bit stp);
      instr_t in;
      in.fw = fw; in.dw = dw; in.mr = mr; in.mw = mw; in.rw = rw;
      in.br = br; in.tk = tk; in.ill = ill; in.stop = stp;
      return in;
   endfunction

   function automatic int rnd_wait();
      if ($urandom_range(9, 0) == 0) return int'($urandom_range(17, 13));
      else                           return int'($urandom_range(3, 0));
   endfunction

   function automatic instr_t rnd_instr();
      return mk(rnd_wait(), rnd_wait(), 1'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), ($urandom_range(15, 0) == 0),
                ($urandom_range(3, 0) == 0));
   endfunction

   // inputs that the current phase does not sample are randomized
   function automatic cyc_t base_cyc();
      cyc_t c;
      c.start = 1'($urandom); c.stop = 1'($urandom);
      c.iack  = 1'($urandom); c.dack = 1'($urandom);
      c.mr = 1'($urandom); c.mw = 1'($urandom); c.rw = 1'($urandom);
      c.br = 1'($urandom); c.ill = 1'($urandom); c.tk = 1'($urandom);
      c.exp = '0; c.busy = 1'b0; c.wb = 1'b0; c.clr = 1'b0;
      return c;
   endfunction

   task automatic add_idle(input int n);
      cyc_t c;
      for (int i = 0; i < n; i++) begin
         c = base_cyc(); c.start = 1'b0; tl.push_back(c);
      end
   endtask

   task automatic add_start();
      cyc_t c;
      c = base_cyc(); c.start = 1'b1; c.clr = 1'b1; tl.push_back(c);
   endtask

   task automatic add_terminal(input logic [9:0] e);
      cyc_t c;
      for (int i = 0; i < 4; i++) begin
         c = base_cyc(); c.exp = e; tl.push_back(c);
      end
   endtask

   task automatic add_instr(input instr_t in, output bit term);
      cyc_t c;
      int   n;
      term = 1'b0;
      n = (in.fw > TMO) ? TMO + 1 : in.fw + 1;
      for (int i = 0; i < n; i++) begin
         c = base_cyc();
         c.iack = (in.fw <= TMO) && (i == n - 1);
         c.exp  = E_IREQ | E_BUSY | (c.iack ? E_IRLD : 10'd0);
         c.busy = 1'b1;
         tl.push_back(c);
      end
      if (in.fw > TMO) begin add_terminal(E_ERR); term = 1'b1; return; end
      c = base_cyc();
      c.mr = in.mr; c.mw = in.mw; c.rw = in.rw; c.br = in.br; c.ill = in.ill;
      c.exp = E_BUSY; c.busy = 1'b1;
      tl.push_back(c);
      if (in.ill) begin add_terminal(E_HALT); term = 1'b1; return; end
      c = base_cyc(); c.tk = in.tk; c.exp = E_BUSY; c.busy = 1'b1;
      tl.push_back(c);
      if (in.mr || in.mw) begin
         n = (in.dw > TMO) ? TMO + 1 : in.dw + 1;
         for (int i = 0; i < n; i++) begin
            c = base_cyc();
            c.dack = (in.dw <= TMO) && (i == n - 1);
            c.exp  = E_DREQ | E_BUSY | (in.mw ? E_DWE : 10'd0);
            c.busy = 1'b1;
            tl.push_back(c);
         end
         if (in.dw > TMO) begin add_terminal(E_ERR); term = 1'b1; return; end
      end
      c = base_cyc();
      c.stop = in.stop;
      c.exp  = E_BUSY | E_PCWE | (in.rw ? E_RFWE : 10'd0) | ((in.br && in.tk) ? E_PCSEL : 10'd0);
      c.busy = 1'b1; c.wb = 1'b1;
      tl.push_back(c);
   endtask

   task automatic build_tl();
      bit term;
      term = 1'b0;
      tl.delete();
      add_idle($urandom_range(2, 0));
      add_start();
      for (int i = 0; i < prog.size(); i++) begin
         if (i == prog.size() - 1) prog[i].stop = 1'b1;
         add_instr(prog[i], term);
         if (term) break;
         if (prog[i].stop && (i != prog.size() - 1)) begin
            add_idle($urandom_range(2, 0));
            add_start();
         end
      end
      if (!term) add_idle(3);
   endtask

   task automatic run_tl(input int lim);
      for (int k = 0; k < lim && k < tl.size(); k++) begin
         @(posedge clk); #1;
         start = tl[k].start; stop = tl[k].stop;
         mem_if.imem_ack = tl[k].iack; mem_if.dmem_ack = tl[k].dack;
         dec_memread = tl[k].mr; dec_memwrite = tl[k].mw; dec_regwrite = tl[k].rw;
         dec_branch = tl[k].br; dec_illegal = tl[k].ill; br_taken = tl[k].tk;
         #1;
         chk($sformatf("outs[%0d]", k), 64'(outs()), 64'(tl[k].exp));
         chk($sformatf("cycle_cnt[%0d]", k), 64'(cycle_cnt), 64'(m_cyc));
         chk($sformatf("retired_cnt[%0d]", k), 64'(retired_cnt), 64'(m_ret));
         if (tl[k].busy) m_cyc = m_cyc + 32'd1;
         if (tl[k].wb)   m_ret = m_ret + 32'd1;
         if (tl[k].clr) begin m_cyc = 32'd0; m_ret = 32'd0; end
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      start = 1'b0; stop = 1'b0; mem_if.imem_ack = 1'b0; mem_if.dmem_ack = 1'b0;
      dec_memread = 1'b0; dec_memwrite = 1'b0; dec_regwrite = 1'b0;
      dec_branch = 1'b0; dec_illegal = 1'b0; br_taken = 1'b0;
      #1;
      chk("rst_outs", 64'(outs()), 64'd0);
      chk("rst_cycle_cnt", 64'(cycle_cnt), 64'd0);
      chk("rst_retired_cnt", 64'(retired_cnt), 64'd0);
      m_cyc = 32'd0; m_ret = 32'd0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic run_prog();
      do_reset();
      build_tl();
      run_tl(tl.size());
   endtask

   initial begin
      rst_n = 1'b1;
      #2;
      // add, ld (3 waits), sd, beq taken/not-taken, ack at wait 15, ld+sd flags, stop then restart
      prog.delete();
      prog.push_back(mk(0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
      prog.push_back(mk(0, 3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      prog.push_back(mk(1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
      prog.push_back(mk(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
      prog.push_back(mk(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
      prog.push_back(mk(15, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      prog.push_back(mk(0, 15, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
      run_prog();
      // illegal op after a retired add
      prog.delete();
      prog.push_back(mk(0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      prog.push_back(mk(0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
      run_prog();
      // fetch timeout, then data-access timeout
      prog.delete();
      prog.push_back(mk(16, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      run_prog();
      prog.delete();
      prog.push_back(mk(0, 16, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      run_prog();
      // reset asserted while a load is waiting in MEMORY
      prog.delete();
      prog.push_back(mk(0, 6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
      do_reset();
      tl.delete();
      add_start();
      begin
         bit t;
         add_instr(prog[0], t);
      end
      run_tl(7);
      chk("pre_rst_dmem_req", 64'(mem_if.dmem_req), 64'd1);
      do_reset();
      // random programs
      for (int e = 0; e < 30; e++) begin
         prog.delete();
         for (int i = 0; i < int'($urandom_range(6, 1)); i++) prog.push_back(rnd_instr());
         run_prog();
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
